// File: rtl/key_pkg.sv
// Shared definitions for the key synchroniser bank.
//   MODE_*  : encodings of the 2-bit LED mode input (11 is reserved and acts as follow)
//   clog2() : ceiling log2, used to size the per-channel debounce counter
package key_pkg;

    localparam logic [1:0] MODE_FOLLOW = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_LATCH  = 2'b10;

    // Smallest width w such that 2**w >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-channel key conditioner: two-flop synchroniser, stability-counter debounce and
// rising-edge pulse.
//   clk_i         : system clock
//   rst_ni        : synchronous active-low reset
//   key_i         : raw asynchronous key level (1 = pressed)
//   stable_o      : registered debounced level
//   stable_next_o : value stable_o takes on the coming edge (lets the parent update in step)
//   rise_o        : stable_o goes 0->1 on the coming edge
//   press_o       : registered one-cycle pulse following an accepted 0->1 transition
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEB_CNT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic stable_o,
    output logic stable_next_o,
    output logic rise_o,
    output logic press_o
);

    localparam int unsigned    CntW   = clog2(DEB_CNT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CNT - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_d;
    logic            press_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Count consecutive cycles where the synchronised level disagrees with the accepted one;
    // any agreement restarts the count, so short bounces never reach CntMax.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= stable_d & ~stable_q;
        end
    end

    assign stable_o      = stable_q;
    assign stable_next_o = stable_d;
    assign rise_o        = stable_d & ~stable_q;
    assign press_o       = press_q;

endmodule

// File: rtl/key_sync_bank.sv
// Multi-channel key-to-LED stage. Each channel is synchronised and debounced by its own
// key_debounce; this level only holds the per-channel LED register and its mode logic.
//   sys_clk : system clock
//   sys_rst : synchronous active-low reset
//   key     : raw asynchronous key levels, one per channel
//   mode    : 00 follow, 01 toggle, 10 latch, 11 follow
//   clr     : clears all LEDs in toggle/latch modes (wins over a same-edge set/toggle)
//   led     : per-channel LED drive
//   press   : one-cycle pulse per accepted press
//   stable  : debounced key levels
module key_sync_bank
    import key_pkg::*;
#(
    parameter int unsigned CH      = 4,
    parameter int unsigned DEB_CNT = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [CH-1:0] key,
    input  logic [1:0]    mode,
    input  logic          clr,
    output logic [CH-1:0] led,
    output logic [CH-1:0] press,
    output logic [CH-1:0] stable
);

    logic [CH-1:0] stable_nxt;
    logic [CH-1:0] rise;
    logic [CH-1:0] led_q;
    logic [CH-1:0] led_d;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        key_debounce #(
            .DEB_CNT(DEB_CNT)
        ) u_debounce (
            .clk_i        (sys_clk),
            .rst_ni       (sys_rst),
            .key_i        (key[g]),
            .stable_o     (stable[g]),
            .stable_next_o(stable_nxt[g]),
            .rise_o       (rise[g]),
            .press_o      (press[g])
        );
    end

    // LED updates on the same edge as stable, using the debouncer's next-state view.
    always_comb begin
        led_d = led_q;
        case (mode)
            MODE_TOGGLE: led_d = clr ? '0 : (led_q ^ rise);
            MODE_LATCH:  led_d = clr ? '0 : (led_q | rise);
            default:     led_d = stable_nxt;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_key_sync_bank.sv
module tb_key_sync_bank;

    localparam int unsigned CH      = 4;
    localparam int unsigned DEB_CNT = 4;
    localparam int          Deb     = int'(DEB_CNT);

    typedef logic [3*CH-1:0] obs_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [CH-1:0] key;
    logic [1:0]    mode;
    logic          clr;
    logic [CH-1:0] led;
    logic [CH-1:0] press;
    logic [CH-1:0] stable;

    int checks = 0;
    int errors = 0;

    // Drive values applied on each tick
    logic [CH-1:0] k_v;
    logic [1:0]    m_v;
    logic          c_v;
    logic          r_v;

    // Reference model state
    logic [CH-1:0] m_s1, m_s2, m_st, m_led, m_pr;
    logic [CH-1:0] m_win[$];   // last DEB_CNT synchronised samples seen by the debouncer
    obs_t          exp_q[$];

    int pc[CH];                // press pulses seen per channel
    int edge_n = 0;

    key_sync_bank #(
        .CH     (CH),
        .DEB_CNT(DEB_CNT)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .key    (key),
        .mode   (mode),
        .clr    (clr),
        .led    (led),
        .press  (press),
        .stable (stable)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // A level is accepted once DEB_CNT consecutive synchronised samples all disagree with it.
    function automatic void model_edge(input logic [CH-1:0] k, input logic [1:0] m,
                                       input logic c, input logic r);
        logic [CH-1:0] nst;
        logic [CH-1:0] rise;
        bit            all_diff;
        if (!r) begin
            m_s1  = '0;
            m_s2  = '0;
            m_st  = '0;
            m_led = '0;
            m_pr  = '0;
            m_win.delete();
        end else begin
            m_win.push_back(m_s2);
            if (m_win.size() > Deb) void'(m_win.pop_front());
            nst = m_st;
            if (m_win.size() == Deb) begin
                for (int i = 0; i < int'(CH); i++) begin
                    all_diff = 1'b1;
                    foreach (m_win[j]) if (m_win[j][i] == m_st[i]) all_diff = 1'b0;
                    if (all_diff) nst[i] = ~m_st[i];
                end
            end
            rise = nst & ~m_st;
            case (m)
                2'b01:   m_led = c ? '0 : (m_led ^ rise);
                2'b10:   m_led = c ? '0 : (m_led | rise);
                default: m_led = nst;
            endcase
            m_pr = rise;
            m_st = nst;
            m_s2 = m_s1;
            m_s1 = k;
        end
        exp_q.push_back({m_led, m_pr, m_st});
    endfunction

    // One clock: drive on the falling edge, record expectation, return #1 after rising edge.
    task automatic tick(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge sys_clk);
            key     = k_v;
            mode    = m_v;
            clr     = c_v;
            sys_rst = r_v;
            model_edge(k_v, m_v, c_v, r_v);
            @(posedge sys_clk);
            #1;
            for (int i = 0; i < int'(CH); i++) if (press[i]) pc[i]++;
        end
    endtask

    // Scoreboard monitor: every edge with a pending expectation is compared.
    initial begin
        obs_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            edge_n++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({led, press, stable} !== e) begin
                    errors++;
                    $display("FAIL sb edge %0d: got led=%b press=%b stable=%b want led=%b press=%b stable=%b",
                             edge_n, led, press, stable, e[3*CH-1:2*CH], e[2*CH-1:CH], e[CH-1:0]);
                end
            end
        end
    end

    initial begin
        logic [CH-1:0] led_before;
        logic [CH-1:0] seen;
        int            n;

        k_v = '0; m_v = 2'b00; c_v = 1'b0; r_v = 1'b0;
        key = '0; mode = 2'b00; clr = 1'b0; sys_rst = 1'b0;
        foreach (pc[i]) pc[i] = 0;

        // Reset
        tick(2);
        chk("reset_led", 32'(led), 32'(0));
        chk("reset_press", 32'(press), 32'(0));
        chk("reset_stable", 32'(stable), 32'(0));
        r_v = 1'b1;
        tick(3);

        // Follow basics: capture edge E, accept at E+5
        k_v = 4'b0001;
        tick(5);
        chk("follow_early", 32'(stable), 32'(0));
        tick(1);
        chk("follow_stable", 32'(stable), 32'(4'b0001));
        chk("follow_led", 32'(led), 32'(4'b0001));
        chk("follow_press", 32'(press), 32'(4'b0001));
        tick(1);
        chk("follow_press_once", 32'(press), 32'(0));

        // Bounce rejection on key[1]
        foreach (pc[i]) pc[i] = 0;
        k_v[1] = 1'b1; tick(3);
        k_v[1] = 1'b0; tick(1);
        k_v[1] = 1'b1; tick(5);
        chk("bounce_hold", 32'(stable[1]), 32'(0));
        tick(1);
        chk("bounce_accept", 32'(stable[1]), 32'(1));
        tick(6);
        chk("bounce_one_press", 32'(pc[1]), 32'(1));

        // Toggle mode on key[2]
        m_v = 2'b01;
        tick(1);
        led_before = led;
        k_v[2] = 1'b1; tick(8);
        chk("toggle_on", 32'(led[2]), 32'(1));
        k_v[2] = 1'b0; tick(8);
        chk("toggle_release", 32'(led[2]), 32'(1));
        k_v[2] = 1'b1; tick(8);
        chk("toggle_off", 32'(led[2]), 32'(0));
        k_v[2] = 1'b0; tick(8);
        chk("toggle_others", 32'(led & 4'b1011), 32'(led_before & 4'b1011));

        // Latch and clear on key[3]
        m_v = 2'b10;
        k_v[3] = 1'b1; tick(8);
        k_v[3] = 1'b0; tick(8);
        chk("latch_held", 32'(led[3]), 32'(1));
        c_v = 1'b1; tick(1); c_v = 1'b0;
        chk("latch_clr", 32'(led), 32'(0));
        k_v[3] = 1'b1; tick(5);
        c_v = 1'b1; tick(1); c_v = 1'b0;
        chk("clr_wins_press", 32'(press[3]), 32'(1));
        chk("clr_wins_led", 32'(led[3]), 32'(0));
        tick(8);
        k_v[3] = 1'b0; tick(8);
        chk("clr_wins_stays", 32'(led[3]), 32'(0));

        // Reset mid-debounce with all keys held
        m_v = 2'b00;
        k_v = '0; tick(10);
        k_v = 4'hF; tick(4);
        r_v = 1'b0; tick(1);
        chk("rst_mid_out", 32'({led, press, stable}), 32'(0));
        tick(1);
        chk("rst_mid_out2", 32'({led, press, stable}), 32'(0));
        r_v = 1'b1; tick(5);
        chk("rst_rel_early", 32'({press, stable}), 32'(0));
        tick(1);
        chk("rst_rel_press", 32'(press), 32'(4'hF));
        chk("rst_rel_stable", 32'(stable), 32'(4'hF));
        tick(1);
        chk("rst_rel_press_once", 32'(press), 32'(0));

        // Stress: pressed levels never last long enough to be accepted
        k_v = '0; tick(10);
        foreach (pc[i]) pc[i] = 0;
        seen = '0;
        for (int it = 0; it < 200; it++) begin
            k_v = ~k_v & CH'($urandom);
            tick(1);
            seen |= stable;
            tick(1);
            seen |= stable;
        end
        chk("stress_stable", 32'(seen), 32'(0));
        chk("stress_press", 32'(pc[0] + pc[1] + pc[2] + pc[3]), 32'(0));

        // Random segments: modes, holds, clears and occasional resets
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 5) == 0) m_v = 2'($urandom_range(0, 3));
            k_v = CH'($urandom);
            c_v = ($urandom_range(0, 7) == 0);
            r_v = ($urandom_range(0, 39) != 0);
            n   = int'($urandom_range(1, 10));
            tick(1);
            c_v = 1'b0;
            r_v = 1'b1;
            if (n > 1) tick(n - 1);
        end

        @(negedge sys_clk);
        chk("sb_drain", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
